draw_hp_bar: RTL and testbench

- VGA pipeline stage between draw_particle and draw_mouse.
- Overlays two health bars on the frame: player 1 (cat) top-left, player 2 (dog) top-right.
- Consumes hp_player1/hp_player2 from simulate. Bars drain in animation, one hp per frame; they flash after a hit.
- Latches game-over and winner status for the game logic.

---
 rtl/hp_bar_pkg.sv | 48 ++++
 rtl/vga_if.sv | 13 +
 rtl/hp_bar_tracker.sv | 61 ++++++
 rtl/draw_hp_bar.sv | 149 ++++++++++++++
 tb/tb_draw_hp_bar.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hp_bar_pkg.sv
// Shared types, colours and helpers for the health-bar overlay stage.
package hp_bar_pkg;

    localparam logic [11:0] COL_BORDER = 12'h000;
    localparam logic [11:0] COL_EMPTY  = 12'h333;
    localparam logic [11:0] COL_HIGH   = 12'h0F0;
    localparam logic [11:0] COL_MID    = 12'hFF0;
    localparam logic [11:0] COL_LOW    = 12'hF00;
    localparam logic [11:0] COL_FLASH  = 12'hFFF;

    localparam logic [6:0] HP_MID = 7'd50;
    localparam logic [6:0] HP_LOW = 7'd20;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        DRAW = 2'b11
    } winner_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_pix_t;

    typedef struct packed {
        logic in_region;
        logic border;
        logic fill;
    } bar_flags_t;

    function automatic logic [6:0] clamp_hp(input logic [6:0] hp, input logic [6:0] cap);
        return (hp > cap) ? cap : hp;
    endfunction

    function automatic logic [11:0] fill_colour(input logic [6:0] disp, input logic flash);
        if (flash)                return COL_FLASH;
        else if (disp > HP_MID)   return COL_HIGH;
        else if (disp > HP_LOW)   return COL_MID;
        else                      return COL_LOW;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between pipeline stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/hp_bar_tracker.sv
// Per-player displayed-hp animation and hit-flash counter.
module hp_bar_tracker
    import hp_bar_pkg::*;
#(
    parameter int HP_MAX       = 100,
    parameter int FLASH_FRAMES = 32
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       tick,
    input  logic [6:0] hp,
    output logic [6:0] disp,
    output logic       flash_phase
);

    localparam int             FW         = $clog2(FLASH_FRAMES + 1);
    localparam logic [6:0]     HP_CAP     = 7'(HP_MAX);
    localparam logic [FW-1:0]  FLASH_LOAD = FW'(FLASH_FRAMES);
    localparam logic [FW-1:0]  FLASH_ONE  = FW'(1);

    logic [6:0]    h;
    logic [6:0]    disp_d, disp_q;
    logic [6:0]    prev_h_d, prev_h_q;
    logic [FW-1:0] flash_d, flash_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        h        = clamp_hp(hp, HP_CAP);
        disp_d   = disp_q;
        flash_d  = flash_q;
        prev_h_d = h;
        if (tick) begin
            if (h < disp_q)
                disp_d = disp_q - 7'd1;
            else if (h > disp_q)
                disp_d = h;
            if (flash_q != '0)
                flash_d = flash_q - FLASH_ONE;
        end
        // A hit outranks the frame decrement so a fresh hit always restarts the full flash.
        if (h < prev_h_q)
            flash_d = FLASH_LOAD;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            disp_q   <= HP_CAP;
            prev_h_q <= HP_CAP;
            flash_q  <= '0;
        end else begin
            disp_q   <= disp_d;
            prev_h_q <= prev_h_d;
            flash_q  <= flash_d;
        end
    end

    assign disp        = disp_q;
    assign flash_phase = flash_q[2];

endmodule

// File: rtl/draw_hp_bar.sv
// VGA stage overlaying two animated health bars; also latches game-over and winner.
module draw_hp_bar
    import hp_bar_pkg::*;
#(
    parameter int HP_MAX       = 100,
    parameter int BAR_Y        = 20,
    parameter int BAR_H        = 12,
    parameter int BAR1_X       = 40,
    parameter int BAR2_X       = 560,
    parameter int PX_PER_HP    = 2,
    parameter int FLASH_FRAMES = 32
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic [6:0] hp_player1,
    input  logic [6:0] hp_player2,
    vga_if.in          in,
    vga_if.out         out,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int          BAR_W  = HP_MAX * PX_PER_HP + 2;
    localparam logic [10:0] Y_LO   = 11'(BAR_Y);
    localparam logic [10:0] Y_HI   = 11'(BAR_Y + BAR_H - 1);
    localparam logic [10:0] X1_LO  = 11'(BAR1_X);
    localparam logic [10:0] X1_HI  = 11'(BAR1_X + BAR_W - 1);
    localparam logic [10:0] X1_IN  = 11'(BAR1_X + 1);
    localparam logic [10:0] X2_LO  = 11'(BAR2_X);
    localparam logic [10:0] X2_HI  = 11'(BAR2_X + BAR_W - 1);
    localparam logic [10:0] X2_IN  = 11'(BAR2_X + BAR_W - 2);
    localparam logic [8:0]  PX_LEN = 9'(PX_PER_HP);

    logic [6:0] disp1, disp2;
    logic       phase1, phase2;
    logic       tick;
    logic       vblnk_d, vblnk_q;
    logic       tick_d, tick_q;
    logic       game_over_d, game_over_q;
    winner_t    winner_d, winner_q;

    logic       row_in, row_edge;
    logic [8:0] len1, len2;
    vga_pix_t   s1_pix_d, s1_pix_q, s2_pix_d, s2_pix_q;
    bar_flags_t bar1_d, bar1_q, bar2_d, bar2_q;

    assign tick = in.vblnk & ~vblnk_q;

    hp_bar_tracker #(.HP_MAX(HP_MAX), .FLASH_FRAMES(FLASH_FRAMES)) u_track1 (
        .clk60MHz    (clk60MHz),
        .rst         (rst),
        .tick        (tick),
        .hp          (hp_player1),
        .disp        (disp1),
        .flash_phase (phase1)
    );

    hp_bar_tracker #(.HP_MAX(HP_MAX), .FLASH_FRAMES(FLASH_FRAMES)) u_track2 (
        .clk60MHz    (clk60MHz),
        .rst         (rst),
        .tick        (tick),
        .hp          (hp_player2),
        .disp        (disp2),
        .flash_phase (phase2)
    );

    // Game over looks one cycle after the tick, when disp already holds this frame's value.
    always_comb begin
        vblnk_d     = in.vblnk;
        tick_d      = tick;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (tick_q && !game_over_q) begin
            if (disp1 == 7'd0 && disp2 == 7'd0) begin
                game_over_d = 1'b1;
                winner_d    = DRAW;
            end else if (disp1 == 7'd0) begin
                game_over_d = 1'b1;
                winner_d    = P2;
            end else if (disp2 == 7'd0) begin
                game_over_d = 1'b1;
                winner_d    = P1;
            end
        end
    end

    always_comb begin
        s1_pix_d = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync, vsync: in.vsync,
                     hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
        row_in   = (in.vcount >= Y_LO) && (in.vcount <= Y_HI);
        row_edge = (in.vcount == Y_LO) || (in.vcount == Y_HI);
        len1     = 9'(disp1) * PX_LEN;
        len2     = 9'(disp2) * PX_LEN;

        bar1_d.in_region = row_in && (in.hcount >= X1_LO) && (in.hcount <= X1_HI);
        bar1_d.border    = bar1_d.in_region && (row_edge || in.hcount == X1_LO || in.hcount == X1_HI);
        bar1_d.fill      = bar1_d.in_region && !bar1_d.border && ((in.hcount - X1_IN) < {2'b00, len1});

        // Bar 2 drains towards its right edge, so measure from the right inner column.
        bar2_d.in_region = row_in && (in.hcount >= X2_LO) && (in.hcount <= X2_HI);
        bar2_d.border    = bar2_d.in_region && (row_edge || in.hcount == X2_LO || in.hcount == X2_HI);
        bar2_d.fill      = bar2_d.in_region && !bar2_d.border && ((X2_IN - in.hcount) < {2'b00, len2});
    end

    always_comb begin
        s2_pix_d = s1_pix_q;
        if (!(s1_pix_q.hblnk || s1_pix_q.vblnk)) begin
            if (bar1_q.in_region)
                s2_pix_d.rgb = bar1_q.border ? COL_BORDER
                             : bar1_q.fill   ? fill_colour(disp1, phase1) : COL_EMPTY;
            else if (bar2_q.in_region)
                s2_pix_d.rgb = bar2_q.border ? COL_BORDER
                             : bar2_q.fill   ? fill_colour(disp2, phase2) : COL_EMPTY;
        end
    end

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            vblnk_q     <= 1'b0;
            tick_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= NONE;
            s1_pix_q    <= '0;
            s2_pix_q    <= '0;
            bar1_q      <= '0;
            bar2_q      <= '0;
        end else begin
            vblnk_q     <= vblnk_d;
            tick_q      <= tick_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            s1_pix_q    <= s1_pix_d;
            s2_pix_q    <= s2_pix_d;
            bar1_q      <= bar1_d;
            bar2_q      <= bar2_d;
        end
    end

    assign out.hcount = s2_pix_q.hcount;
    assign out.vcount = s2_pix_q.vcount;
    assign out.hsync  = s2_pix_q.hsync;
    assign out.vsync  = s2_pix_q.vsync;
    assign out.hblnk  = s2_pix_q.hblnk;
    assign out.vblnk  = s2_pix_q.vblnk;
    assign out.rgb    = s2_pix_q.rgb;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_draw_hp_bar.sv
// Randomised bench for draw_hp_bar against a frame-level model of the health bars.
module tb_draw_hp_bar;

    localparam int HP_MAX = 100;
    localparam int BAR_Y  = 20;
    localparam int BAR_H  = 12;
    localparam int BAR1_X = 40;
    localparam int BAR2_X = 560;
    localparam int PX     = 2;
    localparam int FLASH  = 32;
    localparam int BAR_W  = HP_MAX * PX + 2;

    logic       clk60MHz = 1'b0;
    logic       rst;
    logic [6:0] hp1, hp2;
    logic       game_over;
    logic [1:0] winner;

    vga_if vga_in ();
    vga_if vga_out ();

    always #8 clk60MHz = ~clk60MHz;

    draw_hp_bar #(
        .HP_MAX(HP_MAX), .BAR_Y(BAR_Y), .BAR_H(BAR_H), .BAR1_X(BAR1_X),
        .BAR2_X(BAR2_X), .PX_PER_HP(PX), .FLASH_FRAMES(FLASH)
    ) dut (
        .clk60MHz   (clk60MHz),
        .rst        (rst),
        .hp_player1 (hp1),
        .hp_player2 (hp2),
        .in         (vga_in),
        .out        (vga_out),
        .game_over  (game_over),
        .winner     (winner)
    );

    int m_disp[2];
    int m_flash[2];
    int m_hp[2];
    int m_go, m_win;
    int n_checks = 0;
    int n_pass   = 0;

    int          scan_x;
    logic [38:0] scan_got, scan_exp;

    function automatic int clamp(input int v);
        return (v > HP_MAX) ? HP_MAX : v;
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input logic blank,
                                            input logic [11:0] rin);
        int x0, off;
        if (blank || y < BAR_Y || y > BAR_Y + BAR_H - 1) return rin;
        for (int p = 0; p < 2; p++) begin
            x0 = (p == 0) ? BAR1_X : BAR2_X;
            if (x >= x0 && x <= x0 + BAR_W - 1) begin
                if (x == x0 || x == x0 + BAR_W - 1 || y == BAR_Y || y == BAR_Y + BAR_H - 1)
                    return 12'h000;
                off = (p == 0) ? x - (x0 + 1) : (x0 + BAR_W - 2) - x;
                if (off >= m_disp[p] * PX) return 12'h333;
                if (((m_flash[p] / 4) % 2) == 1) return 12'hFFF;
                if (m_disp[p] > 50) return 12'h0F0;
                if (m_disp[p] > 20) return 12'hFF0;
                return 12'hF00;
            end
        end
        return rin;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_disp[p]  = HP_MAX;
            m_flash[p] = 0;
            m_hp[p]    = HP_MAX;
        end
        m_go  = 0;
        m_win = 0;
    endtask

    task automatic model_hit(input int p, input int v);
        int h;
        h = clamp(v);
        if (h < m_hp[p]) m_flash[p] = FLASH;
        m_hp[p] = h;
    endtask

    task automatic set_hp(input int a, input int b);
        hp1 = 7'(a);
        hp2 = 7'(b);
        model_hit(0, a);
        model_hit(1, b);
        @(posedge clk60MHz); #1;
    endtask

    task automatic frame_tick();
        vga_in.vblnk = 1'b1;
        repeat (2) begin @(posedge clk60MHz); #1; end
        vga_in.vblnk = 1'b0;
        repeat (2) begin @(posedge clk60MHz); #1; end
        for (int p = 0; p < 2; p++) begin
            if (m_hp[p] < m_disp[p])      m_disp[p] = m_disp[p] - 1;
            else if (m_hp[p] > m_disp[p]) m_disp[p] = m_hp[p];
            if (m_flash[p] > 0)           m_flash[p] = m_flash[p] - 1;
        end
        if (m_go == 0) begin
            if (m_disp[0] == 0 && m_disp[1] == 0) begin m_go = 1; m_win = 3; end
            else if (m_disp[0] == 0)              begin m_go = 1; m_win = 2; end
            else if (m_disp[1] == 0)              begin m_go = 1; m_win = 1; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk60MHz); #1; end
        rst = 1'b0;
        model_reset();
        model_hit(0, int'(hp1));
        model_hit(1, int'(hp2));
        @(posedge clk60MHz); #1;
    endtask

    // Streams one row segment through the DUT; returns mismatches, keeping the first for reporting.
    task automatic scan_range(input int y, input int x0, input int x1, input logic hb,
                              output int bad);
        logic [38:0] q[$];
        logic [38:0] got, e;
        logic [11:0] r;
        logic        hs, vs;
        bad = 0;
        for (int i = 0; i <= x1 - x0 + 1; i++) begin
            if (i <= x1 - x0) begin
                r  = 12'($urandom);
                hs = 1'($urandom);
                vs = 1'($urandom);
                vga_in.hcount = 11'(x0 + i);
                vga_in.vcount = 11'(y);
                vga_in.hsync  = hs;
                vga_in.vsync  = vs;
                vga_in.hblnk  = hb;
                vga_in.vblnk  = 1'b0;
                vga_in.rgb    = r;
                q.push_back({11'(x0 + i), 11'(y), hs, vs, hb, 1'b0, exp_rgb(x0 + i, y, hb, r)});
            end
            @(posedge clk60MHz); #1;
            if (i >= 1) begin
                e   = q.pop_front();
                got = {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
                       vga_out.hblnk, vga_out.vblnk, vga_out.rgb};
                if (got !== e) begin
                    if (bad == 0) begin scan_x = x0 + i - 1; scan_got = got; scan_exp = e; end
                    bad++;
                end
            end
        end
        vga_in.hblnk = 1'b0;
    endtask

    task automatic probe_bars(output int bad);
        int y, b, e1, e2;
        y  = BAR_Y + 1 + int'($urandom_range(BAR_H - 3));
        e1 = BAR1_X + 1 + m_disp[0] * PX;
        e2 = BAR2_X + BAR_W - 1 - m_disp[1] * PX;
        scan_range(y, e1 - 2, e1 + 1, 1'b0, bad);
        scan_range(y, e2 - 2, e2 + 1, 1'b0, b);
        bad += b;
    endtask

    task automatic test_reset();
        logic [38:0] o;
        rst = 1'b1;
        repeat (3) begin @(posedge clk60MHz); #1; end
        o = {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
             vga_out.hblnk, vga_out.vblnk, vga_out.rgb};
        n_checks++;
        if ({o, game_over, winner} !== '0)
            $display("FAIL reset_state: got out=%h go=%b win=%b want all zero", o, game_over, winner);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        @(posedge clk60MHz); #1;
    endtask

    task automatic test_full_bars();
        int bad;
        frame_tick();
        scan_range(BAR_Y + 5, BAR1_X - 3, BAR1_X + BAR_W + 2, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL full_bar1 x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        scan_range(BAR_Y + 5, BAR2_X - 3, BAR2_X + BAR_W + 2, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL full_bar2 x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        scan_range(BAR_Y, BAR1_X - 2, BAR1_X + 6, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL top_border x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        scan_range(BAR_Y - 1, BAR1_X - 2, BAR1_X + 6, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL above_bar x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        scan_range(BAR_Y + BAR_H, BAR2_X + 100, BAR2_X + 104, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL below_bar x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        scan_range(BAR_Y + 4, BAR1_X + 10, BAR1_X + 20, 1'b1, bad);
        n_checks++;
        if (bad != 0) $display("FAIL hblank_pass x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
    endtask

    task automatic run_frames(input string name, input int n);
        int bad;
        for (int f = 0; f < n; f++) begin
            frame_tick();
            probe_bars(bad);
            n_checks++;
            if (bad != 0)
                $display("FAIL %s_pixels frame=%0d x=%0d: got %h want %h", name, f, scan_x, scan_got, scan_exp);
            else n_pass++;
            n_checks++;
            if ({game_over, winner} !== {1'(m_go), 2'(m_win)})
                $display("FAIL %s_status frame=%0d: got go=%b win=%b want go=%0d win=%0d",
                         name, f, game_over, winner, m_go, m_win);
            else n_pass++;
        end
    endtask

    task automatic test_hit_flash();
        int bad;
        set_hp(90, 100);
        probe_bars(bad);
        n_checks++;
        if (bad != 0) $display("FAIL flash_pre_tick x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        run_frames("hit_flash", 40);
    endtask

    task automatic test_bar2_drain();
        set_hp(90, 15);
        run_frames("bar2_drain", 90);
    endtask

    task automatic test_game_over();
        set_hp(0, 40);
        run_frames("p1_dies", 95);
        set_hp(100, 40);
        run_frames("sticky", 3);
    endtask

    task automatic test_reset_mid_line();
        int bad;
        logic [38:0] o;
        vga_in.hcount = 11'(BAR1_X + 10);
        vga_in.vcount = 11'(BAR_Y + 3);
        vga_in.rgb    = 12'($urandom);
        repeat (2) @(posedge clk60MHz);
        #3 rst = 1'b1;
        #1;
        o = {vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
             vga_out.hblnk, vga_out.vblnk, vga_out.rgb};
        n_checks++;
        if ({o, game_over, winner} !== '0)
            $display("FAIL async_reset: got out=%h go=%b win=%b want all zero", o, game_over, winner);
        else n_pass++;
        @(posedge clk60MHz); #1;
        rst = 1'b0;
        model_reset();
        model_hit(0, int'(hp1));
        model_hit(1, int'(hp2));
        scan_range(BAR_Y + 6, BAR1_X - 2, BAR1_X + BAR_W + 1, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL after_reset x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        run_frames("post_reset", 2);
    endtask

    task automatic test_draw();
        hp1 = 7'd100;
        hp2 = 7'd100;
        do_reset();
        set_hp(0, 0);
        run_frames("draw", 101);
    endtask

    task automatic test_clamp();
        int bad;
        hp1 = 7'd100;
        hp2 = 7'd100;
        do_reset();
        set_hp(127, 127);
        frame_tick();
        scan_range(BAR_Y + 2, BAR1_X - 1, BAR1_X + BAR_W, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL clamp_bar1 x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
        scan_range(BAR_Y + 9, BAR2_X - 1, BAR2_X + BAR_W, 1'b0, bad);
        n_checks++;
        if (bad != 0) $display("FAIL clamp_bar2 x=%0d: got %h want %h", scan_x, scan_got, scan_exp);
        else n_pass++;
    endtask

    task automatic test_random();
        hp1 = 7'd100;
        hp2 = 7'd100;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            set_hp(int'($urandom_range(127)), int'($urandom_range(127)));
            run_frames("random", 1 + int'($urandom_range(5)));
        end
    endtask

    initial begin
        rst           = 1'b1;
        hp1           = 7'd100;
        hp2           = 7'd100;
        vga_in.hcount = '0;
        vga_in.vcount = '0;
        vga_in.hsync  = 1'b0;
        vga_in.vsync  = 1'b0;
        vga_in.hblnk  = 1'b0;
        vga_in.vblnk  = 1'b0;
        vga_in.rgb    = '0;
        model_reset();

        test_reset();
        test_full_bars();
        test_hit_flash();
        test_bar2_drain();
        test_game_over();
        test_reset_mid_line();
        test_draw();
        test_clamp();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
